// File: rtl/alu_pkg.sv
// Shared definitions for the register-file/ALU execute unit:
// opcodes, flag bit positions, FSM encoding and overflow helpers.
package alu_pkg;

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_ADDC = 8'h07;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_CMP  = 8'h0B;
   localparam logic [7:0] OP_MOV  = 8'h0D;
   localparam logic [7:0] OP_MUL  = 8'h0E;
   localparam logic [7:0] OP_LSH  = 8'h84;

   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb != b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_regfile_pipe_if.sv
// Issue/result bus of the execute unit; the controller is the master,
// the execute unit the slave.
interface alu_regfile_pipe_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16
);
   localparam int SEL_W = $clog2(NUM_REGS);

   logic              in_valid;
   logic              in_ready;
   logic [SEL_W-1:0]  A_Sel;
   logic [SEL_W-1:0]  B_Sel;
   logic [SEL_W-1:0]  Dest_Sel;
   logic              Imm_Sel;
   logic [DATA_W-1:0] Immediate;
   logic [7:0]        OP;
   logic              cin;
   logic              Write_Enable;
   logic              Flags_Enable;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] ALU_Out_Bus;
   logic [SEL_W-1:0]  Out_Dest;
   logic [4:0]        Flag_Reg_Output;

   modport master (
      output in_valid, A_Sel, B_Sel, Dest_Sel, Imm_Sel, Immediate, OP, cin,
             Write_Enable, Flags_Enable, out_ready,
      input  in_ready, out_valid, ALU_Out_Bus, Out_Dest, Flag_Reg_Output
   );

   modport slave (
      input  in_valid, A_Sel, B_Sel, Dest_Sel, Imm_Sel, Immediate, OP, cin,
             Write_Enable, Flags_Enable, out_ready,
      output in_ready, out_valid, ALU_Out_Bus, Out_Dest, Flag_Reg_Output
   );
endinterface

// File: rtl/reg_bank_param.sv
// NUM_REGS x DATA_W register bank: one synchronous write port,
// two combinational read ports, cleared by the asynchronous reset.
module reg_bank_param #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16
) (
   input  logic                        clk,
   input  logic                        Reset,
   input  logic                        i_we,
   input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
   input  logic [DATA_W-1:0]           i_wdata,
   input  logic [$clog2(NUM_REGS)-1:0] i_raddr_a,
   input  logic [$clog2(NUM_REGS)-1:0] i_raddr_b,
   output logic [DATA_W-1:0]           o_rdata_a,
   output logic [DATA_W-1:0]           o_rdata_b
);
   logic [DATA_W-1:0] r_mem [NUM_REGS];

   // Register storage with single write port
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/alu_regfile_pipe.sv
// Execute unit: register bank + ALU with valid/ready issue, registered
// result stage, 5-bit flag register and a shift-add multiplier.
module alu_regfile_pipe
   import alu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16
) (
   input logic               clk,
   input logic               Reset,
   alu_regfile_pipe_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_REGS);
   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = SH_W + 1;

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_alu_out;
   logic [SEL_W-1:0]  r_out_dest;
   logic [4:0]        r_flags;
   logic [DATA_W-1:0] r_mul_a;
   logic [DATA_W-1:0] r_mul_b;
   logic [DATA_W-1:0] r_mul_acc;
   logic [CNT_W-1:0]  r_count;
   logic [SEL_W-1:0]  r_mul_dest;
   logic              r_mul_we;
   logic              r_mul_fe;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_is_mul;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;
   logic [DATA_W-1:0] w_opa;
   logic [DATA_W-1:0] w_opb;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [SH_W-1:0]   w_shamt_l;
   logic [SH_W-1:0]   w_shamt_r;
   logic              w_cin;
   logic [DATA_W-1:0] w_result;
   logic [4:0]        w_flags_next;
   logic              w_op_known;
   logic              w_op_wb;
   logic              w_set_zn;
   logic              w_rf_we;
   logic [SEL_W-1:0]  w_rf_waddr;
   logic [DATA_W-1:0] w_rf_wdata;
   logic              w_flag_we;
   logic [4:0]        w_flag_val;
   logic              w_out_load;
   logic [DATA_W-1:0] w_out_data;

   reg_bank_param #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_reg_bank (
      .clk       (clk),
      .Reset     (Reset),
      .i_we      (w_rf_we),
      .i_waddr   (w_rf_waddr),
      .i_wdata   (w_rf_wdata),
      .i_raddr_a (bus.A_Sel),
      .i_raddr_b (bus.B_Sel),
      .o_rdata_a (w_rd_a),
      .o_rdata_b (w_rd_b)
   );

   assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_is_mul   = (bus.OP == OP_MUL);
   assign w_mul_done = (r_state == ST_BUSY) && (r_count == CNT_W'(DATA_W));

   assign w_opa     = w_rd_a;
   assign w_opb     = bus.Imm_Sel ? bus.Immediate : w_rd_b;
   assign w_cin     = (bus.OP == OP_ADDC) ? bus.cin : 1'b0;
   assign w_sum     = {1'b0, w_opa} + {1'b0, w_opb} + (DATA_W+1)'(w_cin);
   assign w_diff    = {1'b0, w_opa} - {1'b0, w_opb};
   assign w_shamt_l = w_opb[SH_W-1:0];
   // Low bits of -B equal the negation of B's low bits, so no full-width negate is needed
   assign w_shamt_r = {SH_W{1'b0}} - w_opb[SH_W-1:0];

   // Single-cycle ALU result and candidate flag value
   always_comb begin
      w_result     = '0;
      w_flags_next = r_flags;
      w_op_known   = 1'b1;
      w_op_wb      = 1'b1;
      w_set_zn     = 1'b1;
      case (bus.OP)
         OP_AND: w_result = w_opa & w_opb;
         OP_OR:  w_result = w_opa | w_opb;
         OP_XOR: w_result = w_opa ^ w_opb;
         OP_MOV: w_result = w_opb;
         OP_ADD, OP_ADDC: begin
            w_result             = w_sum[DATA_W-1:0];
            w_flags_next[FLAG_C] = w_sum[DATA_W];
            w_flags_next[FLAG_F] = add_ovf(w_opa[DATA_W-1], w_opb[DATA_W-1], w_sum[DATA_W-1]);
         end
         OP_SUB: begin
            w_result             = w_diff[DATA_W-1:0];
            w_flags_next[FLAG_C] = w_diff[DATA_W];
            w_flags_next[FLAG_F] = sub_ovf(w_opa[DATA_W-1], w_opb[DATA_W-1], w_diff[DATA_W-1]);
         end
         OP_CMP: begin
            w_result             = w_diff[DATA_W-1:0];
            w_op_wb              = 1'b0;
            w_set_zn             = 1'b0;
            w_flags_next[FLAG_L] = (w_opa < w_opb);
            w_flags_next[FLAG_N] = ($signed(w_opa) < $signed(w_opb));
            w_flags_next[FLAG_Z] = (w_opa == w_opb);
         end
         OP_LSH: w_result = w_opb[DATA_W-1] ? (w_opa >> w_shamt_r) : (w_opa << w_shamt_l);
         OP_MUL: w_result = '0;
         default: begin
            w_op_known = 1'b0;
            w_op_wb    = 1'b0;
            w_set_zn   = 1'b0;
         end
      endcase
      w_flags_next[FLAG_Z] = w_set_zn ? (w_result == '0) : w_flags_next[FLAG_Z];
      w_flags_next[FLAG_N] = w_set_zn ? w_result[DATA_W-1] : w_flags_next[FLAG_N];
   end

   // FSM state register
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (w_mul_done) begin
               w_state_next = ST_DONE;
            end else begin
               w_state_next = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (w_accept) begin
               w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
            end else if (bus.out_ready) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_DONE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: write-back, flag and result-stage load controls
   always_comb begin
      w_rf_we    = 1'b0;
      w_rf_waddr = '0;
      w_rf_wdata = '0;
      w_flag_we  = 1'b0;
      w_flag_val = r_flags;
      w_out_load = 1'b0;
      w_out_data = '0;
      if (w_mul_done) begin
         w_rf_we            = r_mul_we;
         w_rf_waddr         = r_mul_dest;
         w_rf_wdata         = r_mul_acc;
         w_flag_we          = r_mul_fe;
         w_flag_val[FLAG_Z] = (r_mul_acc == '0);
         w_flag_val[FLAG_N] = r_mul_acc[DATA_W-1];
         w_out_load         = 1'b1;
         w_out_data         = r_mul_acc;
      end else if (w_accept && !w_is_mul) begin
         w_rf_we    = bus.Write_Enable && w_op_wb;
         w_rf_waddr = bus.Dest_Sel;
         w_rf_wdata = w_result;
         w_flag_we  = bus.Flags_Enable && w_op_known;
         w_flag_val = w_flags_next;
         w_out_load = 1'b1;
         w_out_data = w_result;
      end else begin
         w_out_load = 1'b0;
      end
   end

   // Result stage and flag register
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_alu_out  <= '0;
         r_out_dest <= '0;
         r_flags    <= 5'b00000;
      end else begin
         if (w_out_load) begin
            r_alu_out <= w_out_data;
         end
         if (w_accept) begin
            r_out_dest <= bus.Dest_Sel;
         end
         if (w_flag_we) begin
            r_flags <= w_flag_val;
         end
      end
   end

   // Shift-add multiplier: one multiplier bit per BUSY edge, LSB first
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_mul_acc  <= '0;
         r_count    <= '0;
         r_mul_dest <= '0;
         r_mul_we   <= 1'b0;
         r_mul_fe   <= 1'b0;
      end else if (w_accept && w_is_mul) begin
         r_mul_a    <= w_opa;
         r_mul_b    <= w_opb;
         r_mul_acc  <= '0;
         r_count    <= '0;
         r_mul_dest <= bus.Dest_Sel;
         r_mul_we   <= bus.Write_Enable;
         r_mul_fe   <= bus.Flags_Enable;
      end else if ((r_state == ST_BUSY) && !w_mul_done) begin
         if (r_mul_b[0]) begin
            r_mul_acc <= r_mul_acc + r_mul_a;
         end
         r_mul_a <= r_mul_a << 1;
         r_mul_b <= r_mul_b >> 1;
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign bus.in_ready        = w_in_ready;
   assign bus.out_valid       = (r_state == ST_DONE);
   assign bus.ALU_Out_Bus     = r_alu_out;
   assign bus.Out_Dest        = r_out_dest;
   assign bus.Flag_Reg_Output = r_flags;
endmodule

// File: doc/alu_regfile_pipe.md
Name: alu_regfile_pipe

Overview:
Parametrised register-file-plus-ALU execute unit for the CPU datapath, replacing the fixed 16x16 combinational register/ALU slice. Adds a valid/ready issue handshake, a registered result stage with write-back, a 5-bit flag register, and a multi-cycle unsigned multiply (shift-add FSM). The controller issues one operation at a time; results drain to the bus consumer through an output handshake.

Parameters:
DATA_W, 16, datapath and register width (>= 8, power of 2)
NUM_REGS, 16, register count (power of 2, >= 2); SEL_W = clog2(NUM_REGS) derived localparam, not overridable

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation presented
in_ready  out  1  unit can accept operation this cycle
A_Sel  in  SEL_W  operand A register index
B_Sel  in  SEL_W  operand B register index
Dest_Sel  in  SEL_W  write-back register index
Imm_Sel  in  1  1: B operand = Immediate, 0: register B
Immediate  in  DATA_W  immediate operand
OP  in  8  opcode
cin  in  1  carry-in for ADDC
Write_Enable  in  1  write result to Dest_Sel on completion
Flags_Enable  in  1  update flag register on completion
out_valid  out  1  result held on ALU_Out_Bus
out_ready  in  1  consumer takes result
ALU_Out_Bus  out  DATA_W  registered result
Out_Dest  out  SEL_W  Dest_Sel of held result
Flag_Reg_Output  out  5  {C,L,F,Z,N} flag register

Behaviour:
- Reset (Reset=0, async): all registers, flags, ALU_Out_Bus, Out_Dest = 0; out_valid = 0; state IDLE. Reset mid-multiply aborts; no write-back, no flag update.
- States: IDLE (no result), BUSY (multiply iterating), DONE (out_valid=1).
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- Operands sampled at accept from register-file contents at that edge; no bypass needed (write-back always precedes next accept).
- Single-cycle ops: accept at edge k -> DONE at edge k; ALU_Out_Bus, register write (if Write_Enable), flag write (if Flags_Enable) all take effect at edge k. out_valid visible cycle after accept.
- MUL: accept -> BUSY, latch operands, count=0; one bit per edge; after DATA_W BUSY edges -> DONE with result and write-back. out_valid rises DATA_W+1 edges after accept. in_ready=0 throughout BUSY.
- DONE & out_ready & !in_valid -> IDLE. DONE & out_ready & in_valid -> new op accepted same edge (back-to-back, reads previous result from register file).
- DONE & !out_ready: result, Out_Dest held stable; in_ready=0.
- Opcodes (package): AND 0x01, OR 0x02, XOR 0x03, ADD 0x05, ADDC 0x07, SUB 0x09, CMP 0x0B, MOV 0x0D, MUL 0x0E, LSH 0x84.
- Arithmetic mod 2^DATA_W. ADD/ADDC/SUB: C = carry-out (SUB: borrow), F = signed overflow. ADDC adds cin.
- CMP: result = A-B, write-back suppressed regardless of Write_Enable; L = A<B unsigned, N = A<B signed, Z = A==B.
- Non-CMP ops: Z = (result==0), N = result MSB; L unchanged; logic/MOV/LSH leave C,F unchanged.
- MUL: low DATA_W bits of unsigned A*B; Z,N updated, C,L,F unchanged.
- LSH: B MSB=0 -> A << B[clog2(DATA_W)-1:0]; MSB=1 -> A >> (-B)[clog2(DATA_W)-1:0] logical.
- Undefined opcode: result 0, no write-back, no flag update, completes single-cycle.
- Dest write and flag write independent; Flags_Enable=0 leaves flags untouched.

Decomposition:
- Package alu_pkg: opcode localparams, flag bit indices (C=4,L=3,F=2,Z=1,N=0), state encoding.
- One sub-module: reg_bank_param (NUM_REGS x DATA_W, async-reset, single write port, two combinational read ports).

Test Plan:
- Reset then read r0..r15 via MOV -> all results 0, Flag_Reg_Output=0, out_valid=0 during reset.
- MOV Imm 0x7FFF->r1; ADD r1+Imm 1 ->r2, Flags_Enable=1 -> 0x8000, F=1, N=1, Z=0, C=0.
- CMP r1 (0x0003) vs Imm 0xFFFF -> L=1, N=0, Z=0; r-dest unchanged despite Write_Enable=1.
- MUL 0x0123*0x0010 -> r3=0x1230; out_valid exactly 17 cycles after accept; in_ready=0 in between.
- Back-to-back: hold out_ready=1, issue ADD r4=r4+1 twice consecutively -> results 1 then 2, one per cycle.
- Assert Reset at BUSY cycle 5 of MUL -> dest register stays prior value, out_valid=0, state IDLE after release.
